// File: rtl/reg_file_sb.sv
// Decode-stage register file: 2 async read ports, 1 sync write port, optional
// hardwired-zero register, write-to-read bypass, busy scoreboard and post-reset clear sweep.
module reg_file_sb #(
  parameter int DATA_W    = 64,
  parameter int ADDR_W    = 5,
  parameter bit ZERO_EN   = 1'b1,
  parameter int ZERO_IDX  = 31,
  parameter bit BYPASS_EN = 1'b1
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic [ADDR_W-1:0] READ_REG_A,
  input  logic [ADDR_W-1:0] READ_REG_B,
  output logic [DATA_W-1:0] DATA_OUT_A,
  output logic [DATA_W-1:0] DATA_OUT_B,
  output logic              BUSY_A,
  output logic              BUSY_B,
  input  logic [ADDR_W-1:0] WRITE_REG,
  input  logic [DATA_W-1:0] WRITE_DATA,
  input  logic              REG_WRITE_ENABLE,
  input  logic              RESERVE_EN,
  input  logic [ADDR_W-1:0] RESERVE_REG,
  output logic              READY
);
  localparam int               NREG = 2**ADDR_W;
  localparam logic [ADDR_W-1:0] ZIDX = ADDR_W'(ZERO_IDX);
  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(NREG-1);

  typedef enum logic {SWEEP, RUN} state_t;

  state_t            state, next_state;
  logic [ADDR_W-1:0] cnt;
  logic [DATA_W-1:0] regs [NREG];
  logic [NREG-1:0]   busy;
  logic              sweep_wr, wr_ok, res_ok;

  always_ff @(posedge CLK) begin
    if (RESET) state <= SWEEP;
    else       state <= next_state;
  end

  always_comb begin
    next_state = state;
    READY      = 1'b0;
    sweep_wr   = 1'b0;
    case (state)
      SWEEP: begin
        sweep_wr = 1'b1;
        if (cnt == LAST) next_state = RUN;
      end
      RUN:     READY = 1'b1;
      default: next_state = SWEEP;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RESET)         cnt <= '0;
    else if (sweep_wr) cnt <= cnt + 1'b1;
  end

  assign wr_ok  = READY && REG_WRITE_ENABLE && !(ZERO_EN && WRITE_REG == ZIDX);
  assign res_ok = READY && RESERVE_EN && !(ZERO_EN && RESERVE_REG == ZIDX);

  // Contents are left untouched while RESET is high; the sweep clears them afterwards.
  always_ff @(posedge CLK) begin
    if (!RESET) begin
      if (sweep_wr)   regs[cnt]       <= '0;
      else if (wr_ok) regs[WRITE_REG] <= WRITE_DATA;
    end
  end

  // Reserve is applied after the write clear so a same-cycle new producer wins.
  always_ff @(posedge CLK) begin
    if (RESET) busy <= '0;
    else begin
      if (wr_ok)  busy[WRITE_REG]   <= 1'b0;
      if (res_ok) busy[RESERVE_REG] <= 1'b1;
    end
  end

  logic [1:0][ADDR_W-1:0] raddr;
  logic [1:0][DATA_W-1:0] rdata;
  logic [1:0]             rbusy;

  assign raddr = {READ_REG_B, READ_REG_A};

  for (genvar p = 0; p < 2; p++) begin : g_rd
    logic is_zero, byp;
    assign is_zero = ZERO_EN && raddr[p] == ZIDX;
    assign byp     = BYPASS_EN && REG_WRITE_ENABLE && WRITE_REG == raddr[p];
    always_comb begin
      rdata[p] = '0;
      rbusy[p] = 1'b0;
      if (READY && !is_zero) begin
        rdata[p] = byp ? WRITE_DATA : regs[raddr[p]];
        rbusy[p] = byp ? 1'b0 : busy[raddr[p]];
      end
    end
  end

  assign DATA_OUT_A = rdata[0];
  assign DATA_OUT_B = rdata[1];
  assign BUSY_A     = rbusy[0];
  assign BUSY_B     = rbusy[1];
endmodule

// File: tb/tb_reg_file_sb.sv
// Scoreboard bench for reg_file_sb: three variants (default, ZERO_IDX=0, BYPASS_EN=0)
// share one stimulus stream; expectations are queued and checked on the falling edge.
module tb_reg_file_sb;
  localparam int SIG_DA = 0, SIG_DB = 1, SIG_BA = 2, SIG_BB = 3, SIG_RDY = 4;

  logic        CLK = 1'b0;
  logic        RESET;
  logic [4:0]  READ_REG_A, READ_REG_B, WRITE_REG, RESERVE_REG;
  logic [63:0] WRITE_DATA;
  logic        REG_WRITE_ENABLE, RESERVE_EN;

  logic [63:0] da [3];
  logic [63:0] db [3];
  logic        ba [3];
  logic        bb [3];
  logic        rdy [3];

  always #5 CLK = ~CLK;

  reg_file_sb u_def (
    .CLK(CLK), .RESET(RESET), .READ_REG_A(READ_REG_A), .READ_REG_B(READ_REG_B),
    .DATA_OUT_A(da[0]), .DATA_OUT_B(db[0]), .BUSY_A(ba[0]), .BUSY_B(bb[0]),
    .WRITE_REG(WRITE_REG), .WRITE_DATA(WRITE_DATA), .REG_WRITE_ENABLE(REG_WRITE_ENABLE),
    .RESERVE_EN(RESERVE_EN), .RESERVE_REG(RESERVE_REG), .READY(rdy[0]));

  reg_file_sb #(.ZERO_IDX(0)) u_z0 (
    .CLK(CLK), .RESET(RESET), .READ_REG_A(READ_REG_A), .READ_REG_B(READ_REG_B),
    .DATA_OUT_A(da[1]), .DATA_OUT_B(db[1]), .BUSY_A(ba[1]), .BUSY_B(bb[1]),
    .WRITE_REG(WRITE_REG), .WRITE_DATA(WRITE_DATA), .REG_WRITE_ENABLE(REG_WRITE_ENABLE),
    .RESERVE_EN(RESERVE_EN), .RESERVE_REG(RESERVE_REG), .READY(rdy[1]));

  reg_file_sb #(.BYPASS_EN(1'b0)) u_nb (
    .CLK(CLK), .RESET(RESET), .READ_REG_A(READ_REG_A), .READ_REG_B(READ_REG_B),
    .DATA_OUT_A(da[2]), .DATA_OUT_B(db[2]), .BUSY_A(ba[2]), .BUSY_B(bb[2]),
    .WRITE_REG(WRITE_REG), .WRITE_DATA(WRITE_DATA), .REG_WRITE_ENABLE(REG_WRITE_ENABLE),
    .RESERVE_EN(RESERVE_EN), .RESERVE_REG(RESERVE_REG), .READY(rdy[2]));

  typedef struct {
    int          dut;
    int          sig;
    logic [63:0] val;
    string       name;
  } exp_t;

  exp_t q[$];
  int   tests = 0;
  int   fails = 0;

  function automatic logic [63:0] get_val(input int dut, input int sig);
    case (sig)
      SIG_DA:  return da[dut];
      SIG_DB:  return db[dut];
      SIG_BA:  return {63'd0, ba[dut]};
      SIG_BB:  return {63'd0, bb[dut]};
      default: return {63'd0, rdy[dut]};
    endcase
  endfunction

  task automatic chk(input int dut, input int sig, input logic [63:0] val, input string name);
    exp_t e;
    e.dut = dut; e.sig = sig; e.val = val; e.name = name;
    q.push_back(e);
  endtask

  always @(posedge CLK)
    if (REG_WRITE_ENABLE && rdy[0])
      $display("[TB] t=%0t write r%0d = %h", $time, WRITE_REG, WRITE_DATA);

  // Monitor: the read side is combinational, so every pending expectation is
  // compared mid-cycle against what the DUTs present.
  always @(negedge CLK) begin
    while (q.size() > 0) begin
      exp_t e;
      logic [63:0] act;
      e   = q.pop_front();
      act = get_val(e.dut, e.sig);
      tests++;
      if (act !== e.val) begin
        fails++;
        $display("FAIL %s (dut%0d): got %h expected %h", e.name, e.dut, act, e.val);
      end
    end
  end

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  initial begin
    RESET = 1'b1; READ_REG_A = '0; READ_REG_B = '0; WRITE_REG = '0; RESERVE_REG = '0;
    WRITE_DATA = '0; REG_WRITE_ENABLE = 1'b0; RESERVE_EN = 1'b0;
    tick(); tick();
    RESET = 1'b0;
    chk(0, SIG_RDY, 0, "reset_ready");
    chk(0, SIG_BA, 0, "reset_busy_a");
    chk(0, SIG_DA, 0, "reset_data_a");

    // Sweep: READY must rise on exactly the 32nd posedge; write of 5 to r3 is dropped.
    for (int k = 1; k <= 32; k++) begin
      tick();
      REG_WRITE_ENABLE = (k == 4);
      WRITE_REG        = 5'd3;
      WRITE_DATA       = 64'd5;
      READ_REG_A       = 5'd3;
      chk(0, SIG_RDY, (k == 32) ? 64'd1 : 64'd0, "sweep_ready");
      if (k < 32) chk(0, SIG_DA, 0, "sweep_read_zero");
    end
    REG_WRITE_ENABLE = 1'b0;

    for (int i = 0; i < 32; i++) begin
      READ_REG_A = 5'(i);
      READ_REG_B = 5'(31 - i);
      chk(0, SIG_DA, 0, "post_sweep_a");
      chk(0, SIG_DB, 0, "post_sweep_b");
      tick();
    end

    REG_WRITE_ENABLE = 1'b1; WRITE_REG = 5'd1; WRITE_DATA = 64'hDEAD_BEEF_0000_0001;
    READ_REG_A = 5'd2;
    tick();
    REG_WRITE_ENABLE = 1'b0; READ_REG_A = 5'd1;
    chk(0, SIG_DA, 64'hDEAD_BEEF_0000_0001, "write_read_r1");
    tick();

    REG_WRITE_ENABLE = 1'b1; WRITE_REG = 5'd31; WRITE_DATA = 64'h1234;
    tick();
    REG_WRITE_ENABLE = 1'b0; READ_REG_B = 5'd31;
    chk(0, SIG_DB, 0, "zero_reg_31");
    chk(1, SIG_DB, 64'h1234, "r31_not_zero_idx");
    chk(2, SIG_DB, 0, "zero_reg_31_nb");
    tick();

    // Bypass: same-cycle read of the register being written.
    REG_WRITE_ENABLE = 1'b1; WRITE_REG = 5'd7; WRITE_DATA = 64'hA5; READ_REG_A = 5'd7;
    chk(0, SIG_DA, 64'hA5, "bypass_on");
    chk(2, SIG_DA, 0, "bypass_off_old");
    tick();
    REG_WRITE_ENABLE = 1'b0;
    chk(2, SIG_DA, 64'hA5, "bypass_off_after");
    tick();

    // Scoreboard on r4.
    RESERVE_EN = 1'b1; RESERVE_REG = 5'd4; READ_REG_A = 5'd4;
    chk(0, SIG_BA, 0, "reserve_not_same_cycle");
    tick();
    RESERVE_EN = 1'b0;
    chk(0, SIG_BA, 1, "reserve_r4_busy");
    tick();
    REG_WRITE_ENABLE = 1'b1; WRITE_REG = 5'd4; WRITE_DATA = 64'h44;
    chk(0, SIG_BA, 0, "write_masks_busy");
    chk(2, SIG_BA, 1, "no_bypass_no_mask");
    tick();
    REG_WRITE_ENABLE = 1'b0;
    chk(0, SIG_BA, 0, "write_clears_busy");
    chk(0, SIG_DA, 64'h44, "r4_data");
    tick();

    RESERVE_EN = 1'b1; RESERVE_REG = 5'd31;
    tick();
    RESERVE_EN = 1'b0; READ_REG_A = 5'd31;
    chk(0, SIG_BA, 0, "zero_reg_never_busy");
    chk(1, SIG_BA, 1, "r31_busy_zero_idx0");
    tick();

    // Simultaneous write + reserve on r9: new producer wins.
    REG_WRITE_ENABLE = 1'b1; WRITE_REG = 5'd9; WRITE_DATA = 64'h99;
    RESERVE_EN = 1'b1; RESERVE_REG = 5'd9; READ_REG_A = 5'd9;
    chk(0, SIG_DA, 64'h99, "wr_res_bypass");
    chk(0, SIG_BA, 0, "wr_res_busy_now");
    tick();
    REG_WRITE_ENABLE = 1'b0; RESERVE_EN = 1'b0;
    chk(0, SIG_DA, 64'h99, "wr_res_data");
    chk(0, SIG_BA, 1, "wr_res_busy_next");
    tick();
    REG_WRITE_ENABLE = 1'b1; WRITE_DATA = 64'h100;
    tick();
    REG_WRITE_ENABLE = 1'b0;
    chk(0, SIG_BA, 0, "r9_busy_cleared");
    chk(0, SIG_DA, 64'h100, "r9_data");
    tick();

    // Reset mid-operation.
    REG_WRITE_ENABLE = 1'b1; WRITE_REG = 5'd2; WRITE_DATA = 64'h77;
    tick();
    REG_WRITE_ENABLE = 1'b0; RESERVE_EN = 1'b1; RESERVE_REG = 5'd2;
    tick();
    RESERVE_REG = 5'd5;
    tick();
    RESERVE_EN = 1'b0; READ_REG_A = 5'd2; READ_REG_B = 5'd5;
    chk(0, SIG_BA, 1, "busy_r2_set");
    chk(0, SIG_BB, 1, "busy_r5_set");
    chk(0, SIG_DA, 64'h77, "r2_before_reset");
    RESET = 1'b1;
    tick();
    RESET = 1'b0;
    chk(0, SIG_RDY, 0, "midreset_ready");
    chk(0, SIG_BA, 0, "midreset_busy_a");
    chk(0, SIG_BB, 0, "midreset_busy_b");
    for (int k = 0; k < 10; k++) tick();
    RESET = 1'b1;
    tick();
    RESET = 1'b0;
    chk(0, SIG_RDY, 0, "restart_ready");
    for (int k = 1; k <= 32; k++) begin
      tick();
      chk(0, SIG_RDY, (k == 32) ? 64'd1 : 64'd0, "restart_sweep_ready");
    end
    chk(0, SIG_DA, 0, "r2_cleared");
    chk(0, SIG_BA, 0, "r2_not_busy");
    chk(0, SIG_BB, 0, "r5_not_busy");
    tick();
    tick();

    if (q.size() != 0) begin
      fails++;
      $display("FAIL scoreboard_drain: %0d left expected 0", q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/reg_file_sb.md
Name: reg_file_sb

Overview:
- Parametrised successor to the pipeline's general-purpose register file.
- Keeps 2 asynchronous read ports and 1 synchronous write port; adds the following:
  - configurable data width and register count;
  - configurable hardwired-zero register;
  - same-cycle write-to-read bypass;
  - per-register scoreboard (busy bits) for hazard detection in ID;
  - post-reset sweep FSM that clears every register.
- Sits in the decode stage. Write port is driven by WB; reserve port is driven by ID on issue.

Parameters:
- DATA_W, 64, register width in bits.
- ADDR_W, 5, address width; register count NREG = 2**ADDR_W.
- ZERO_EN, 1, 1 = register ZERO_IDX reads as 0, ignores writes, never busy.
- ZERO_IDX, 31, index of the hardwired-zero register (XZR).
- BYPASS_EN, 1, 1 = a read of the register being written this cycle returns WRITE_DATA.

Ports:
- CLK  in  1  system clock, all state updates on posedge.
- RESET  in  1  synchronous, active-high reset.
- READ_REG_A  in  ADDR_W  read address, port A.
- READ_REG_B  in  ADDR_W  read address, port B.
- DATA_OUT_A  out  DATA_W  read data, port A (combinational).
- DATA_OUT_B  out  DATA_W  read data, port B (combinational).
- BUSY_A  out  1  scoreboard bit for READ_REG_A (combinational).
- BUSY_B  out  1  scoreboard bit for READ_REG_B (combinational).
- WRITE_REG  in  ADDR_W  write address.
- WRITE_DATA  in  DATA_W  write data.
- REG_WRITE_ENABLE  in  1  commit WRITE_DATA to WRITE_REG on posedge; clears that busy bit.
- RESERVE_EN  in  1  set busy bit of RESERVE_REG on posedge.
- RESERVE_REG  in  ADDR_W  destination register being issued.
- READY  out  1  1 = sweep done, file accepts writes and reservations.

Behaviour:
- State machine: SWEEP, RUN. The FSM has no other states.
- RESET=1 at posedge, whatever the current state:
  - state <= SWEEP, sweep counter <= 0, all busy bits <= 0.
  - Register contents are not written during the reset cycle.
- SWEEP:
  - Each posedge with RESET=0 writes REGISTER[cnt] <= 0, then cnt <= cnt+1.
  - When cnt == NREG-1 that register is cleared, and state <= RUN.
  - Sweep takes exactly NREG cycles after RESET deasserts; READY rises on the NREG-th posedge.
  - RESET re-asserted mid-sweep restarts the sweep from cnt=0.
- During SWEEP:
  - READY=0.
  - DATA_OUT_A/B = 0 and BUSY_A/B = 0 regardless of address.
  - REG_WRITE_ENABLE and RESERVE_EN are ignored; nothing is queued.
- RUN, read port X (A or B), evaluated in priority order:
  1. ZERO_EN and addr == ZERO_IDX: data 0.
  2. BYPASS_EN and REG_WRITE_ENABLE and WRITE_REG == addr: data WRITE_DATA.
  3. Otherwise: REGISTER[addr].
- RUN, write:
  - On posedge with REG_WRITE_ENABLE=1 and (not ZERO_EN or WRITE_REG != ZERO_IDX): REGISTER[WRITE_REG] <= WRITE_DATA, busy[WRITE_REG] <= 0.
  - A write to ZERO_IDX (ZERO_EN=1) changes nothing.
- RUN, reserve:
  - On posedge with RESERVE_EN=1 and RESERVE_REG not the zero register: busy[RESERVE_REG] <= 1.
  - Simultaneous write and reserve of the same register: data is written and busy ends at 1 (the new producer wins).
  - Reserve of an already-busy register: it stays 1.
- BUSY_X:
  - Equals busy[addr], masked to 0 when the write port commits to addr in the same cycle (BYPASS_EN=1 only).
  - Always 0 for the zero register.
  - BUSY_X is not masked by a same-cycle reserve; that reserve is visible from the next cycle.
- Both read ports may address the same register; outputs are identical.
- Reset values: READY=0, BUSY_A/B=0, DATA_OUT_A/B=0, all busy bits 0. Registers are 0 once the sweep completes.
- Simulation only: $display on each committed write with time, register and value.

Test Plan:
- Sweep: run with X-filled memory, RESET high 2 cycles then low.
  - Required: READY=0 for exactly 32 posedges, then 1.
  - Required: reads of regs 0..31 all return 0.
  - Required: a write of 5 to reg 3 issued during the sweep is dropped; reg 3 still reads 0.
- Write/read and zero register:
  - Write reg 1 = 64'hDEAD_BEEF_0000_0001; next cycle READ_REG_A=1 returns it.
  - Write reg 31 = 64'h1234; READ_REG_B=31 returns 0.
  - With ZERO_IDX=0, reg 31 does hold 64'h1234.
- Bypass:
  - Same cycle: REG_WRITE_ENABLE=1, WRITE_REG=7, WRITE_DATA=64'hA5, READ_REG_A=7. DATA_OUT_A=64'hA5 before the edge.
  - With BYPASS_EN=0, DATA_OUT_A shows the old value (0).
- Scoreboard:
  - Reserve reg 4 → BUSY_A=1 (READ_REG_A=4) from the next cycle.
  - Write reg 4 → BUSY_A=0 combinationally in the write cycle and registered 0 after.
  - Reserve reg 31 → BUSY stays 0.
- Simultaneous write+reserve on reg 9 → reg 9 = new data and BUSY=1 the next cycle. A later write of 9 clears BUSY.
- Reset mid-operation:
  - Set busy on regs 2 and 5, assert RESET at sweep count 10 → READY=0, all BUSY=0.
  - Required: sweep restarts and READY=1 exactly 32 cycles after RESET falls; reg 2 reads 0.
